// File: rtl/separador.sv
// Block splitter: 2-entry FIFO that returns header [127:32] and nonce [31:0].
// Define SEPARADOR_SEQ_CHECK_EN to add the sticky nonce-sequence checker.
module separador #(
  parameter int ANCHO_BLOQUE = 128,
  parameter int ANCHO_NONCE  = 32,
  parameter int ANCHO_CONT   = 16
) (
  input  logic                            clk,
  input  logic                            reset_L,
  input  logic [ANCHO_BLOQUE-1:0]         bloque_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [ANCHO_BLOQUE-ANCHO_NONCE-1:0] entrada,
  output logic [ANCHO_NONCE-1:0]          nonce,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ANCHO_CONT-1:0]           cont_bloques,
  output logic                            err_seq
);

  typedef enum logic [1:0] {
    VACIO = 2'd0,
    UNO   = 2'd1,
    LLENO = 2'd2
  } nivel_e;

  nivel_e nivel_q, nivel_d;

  logic [1:0][ANCHO_BLOQUE-1:0] mem_q, mem_d;
  logic wptr_q, wptr_d;
  logic rptr_q, rptr_d;
  logic [ANCHO_CONT-1:0] cont_q, cont_d;
  logic [ANCHO_BLOQUE-1:0] cabeza;
  logic push, pop;

  // in_ready is forced low while the block is held in reset
  assign in_ready  = reset_L & (nivel_q != LLENO);
  assign out_valid = (nivel_q != VACIO);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign cabeza  = mem_q[rptr_q];
  assign entrada = out_valid ? cabeza[ANCHO_BLOQUE-1:ANCHO_NONCE] : '0;
  assign nonce   = out_valid ? cabeza[ANCHO_NONCE-1:0] : '0;

  assign cont_bloques = cont_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cont_d = cont_q;
    if (push) begin
      mem_d[wptr_q] = bloque_in;
      wptr_d        = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
      cont_d = cont_q + ANCHO_CONT'(1);
    end
  end

  always_comb begin
    nivel_d = nivel_q;
    unique case (nivel_q)
      VACIO: if (push) nivel_d = UNO;
      UNO: begin
        if (push && !pop)      nivel_d = LLENO;
        else if (!push && pop) nivel_d = VACIO;
      end
      LLENO: if (pop) nivel_d = UNO;
      default: nivel_d = VACIO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      nivel_q <= VACIO;
      mem_q   <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      cont_q  <= '0;
    end else begin
      nivel_q <= nivel_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cont_q  <= cont_d;
    end
  end

`ifdef SEPARADOR_SEQ_CHECK_EN
  logic [ANCHO_NONCE-1:0] esperado_q, esperado_d;
  logic armado_q, armado_d;
  logic err_q, err_d;

  always_comb begin
    esperado_d = esperado_q;
    armado_d   = armado_q;
    err_d      = err_q;
    if (pop) begin
      if (armado_q && (nonce != esperado_q)) err_d = 1'b1;
      esperado_d = nonce + ANCHO_NONCE'(1);
      armado_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      esperado_q <= '0;
      armado_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      esperado_q <= esperado_d;
      armado_q   <= armado_d;
      err_q      <= err_d;
    end
  end

  assign err_seq = err_q;
`else
  assign err_seq = 1'b0;
`endif

endmodule

// File: tb/tb_separador.sv
// Randomized + directed bench for separador against a queue-based model.
// Honours SEPARADOR_SEQ_CHECK_EN for the err_seq expectation.
module tb_separador;

  logic         clk;
  logic         reset_L;
  logic [127:0] bloque_in;
  logic         in_valid;
  logic         in_ready;
  logic [95:0]  entrada;
  logic [31:0]  nonce;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  cont_bloques;
  logic         err_seq;

  separador dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .bloque_in    (bloque_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .entrada      (entrada),
    .nonce        (nonce),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .cont_bloques (cont_bloques),
    .err_seq      (err_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] mq[$];
  int           m_cont;
  bit           m_armado;
  logic [31:0]  m_esp;
  bit           m_err;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] blk(input logic [95:0] h,
                                       input logic [31:0] n);
    return {h, n};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cont   = 0;
    m_armado = 0;
    m_esp    = '0;
    m_err    = 0;
  endtask

  task automatic check_all();
    logic [127:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("entrada", entrada, h[127:32]);
    chk("nonce", nonce, h[31:0]);
    chk("cont", cont_bloques, m_cont);
`ifdef SEPARADOR_SEQ_CHECK_EN
    chk("err_seq", err_seq, m_err);
`else
    chk("err_seq", err_seq, 1'b0);
`endif
  endtask

  task automatic step(input logic v, input logic [127:0] d, input logic r);
    bit do_push, do_pop;
    logic [31:0] pn;
    in_valid  = v;
    bloque_in = d;
    out_ready = r;
    do_push = v && (mq.size() < 2);
    do_pop  = r && (mq.size() > 0);
    @(posedge clk);
    if (do_pop) begin
      pn = mq[0][31:0];
      void'(mq.pop_front());
      m_cont = (m_cont + 1) % 65536;
      if (m_armado && pn != m_esp) m_err = 1;
      m_esp    = pn + 32'd1;
      m_armado = 1;
    end
    if (do_push) mq.push_back(d);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset_L   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bloque_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cont", cont_bloques, 16'h0);
    reset_L = 1'b1;
    #1;
    check_all();
  endtask

  localparam logic [95:0] HDR = 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC;

  initial begin
    do_reset();

    // single push, no pop
    step(1, blk(HDR, 32'h5), 0);
    chk("t1_entrada", entrada, HDR);
    chk("t1_nonce", nonce, 32'h5);
    step(0, '0, 1);

    // back-pressure
    do_reset();
    step(1, blk(HDR, 32'd1), 0);
    step(1, blk(HDR, 32'd2), 0);
    chk("t2_full", in_ready, 1'b0);
    step(1, blk(HDR, 32'd3), 0);
    step(1, blk(HDR, 32'd3), 1);
    chk("t2_pop1", nonce, 32'd2);
    step(1, blk(HDR, 32'd3), 1);
    chk("t2_cont", cont_bloques, 16'd2);
    step(1, blk(HDR, 32'd3), 0);
    chk("t2_n3", nonce, 32'd3);
    step(0, '0, 1);

    // streaming 10..19
    do_reset();
    for (int i = 10; i < 20; i++) begin
      step(1, blk(HDR ^ 96'(i), 32'(i)), 1);
      chk("t3_ready", in_ready, 1'b1);
    end
    step(0, '0, 1);
    chk("t3_cont", cont_bloques, 16'd10);

    // async reset mid-cycle
    step(1, blk(HDR, 32'h77), 0);
    step(1, blk(HDR, 32'h78), 0);
    #2 reset_L = 1'b0;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_entrada", entrada, 96'h0);
    chk("ar_nonce", nonce, 32'h0);
    chk("ar_cont", cont_bloques, 16'h0);
    chk("ar_ready", in_ready, 1'b0);
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
    step(0, '0, 1);
    step(0, '0, 1);

    // sequence checker
    do_reset();
    step(1, blk(HDR, 32'hFFFFFFFE), 1);
    step(1, blk(HDR, 32'hFFFFFFFF), 1);
    step(1, blk(HDR, 32'h00000000), 1);
    step(1, blk(HDR, 32'h00000001), 1);
    step(1, blk(HDR, 32'h00000005), 1);
    step(1, blk(HDR, 32'h00000006), 1);
    step(1, blk(HDR, 32'h00000007), 1);
    step(0, '0, 1);
`ifdef SEPARADOR_SEQ_CHECK_EN
    chk("seq_err", err_seq, 1'b1);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 2) != 0);
    end

    // counter wrap
    do_reset();
    for (int i = 0; i <= 65536; i++) begin
      step(1, blk(HDR, 32'(i)), 1);
    end
    chk("wrap_cont", cont_bloques, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/separador.md
Name: separador

Overview:
- Inverse of the hash-input concatenation stage.
- Accepts 128-bit assembled blocks over a valid/ready handshake, buffers them in a 2-entry FIFO, and splits each block back into its 96-bit header field and 32-bit nonce field.
- Sits on the result/readback path: it returns the header and the nonce that produced a hash to the nonce-search controller and to the verification bench.
- Also keeps a running count of delivered blocks.

Parameters:
- ANCHO_BLOQUE, 128, input block width; fixed at 128 for this design.
- ANCHO_NONCE, 32, nonce field width; occupies the low bits of the block.
- ANCHO_CONT, 16, width of the delivered-block counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- bloque_in  input  128  assembled block: header in [127:32], nonce in [31:0].
- in_valid  input  1  bloque_in holds a valid block this cycle.
- in_ready  output  1  block can accept bloque_in this cycle.
- entrada  output  96  header field of the FIFO head entry.
- nonce  output  32  nonce field of the FIFO head entry.
- out_valid  output  1  entrada/nonce valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- cont_bloques  output  16  number of entries popped since reset.
- err_seq  output  1  sticky nonce-sequence error; exists only with the optional feature, otherwise driven 0.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - FIFO count = 0; read and write pointers = 0.
  - entrada = 0, nonce = 0, out_valid = 0.
  - in_ready = 0 while reset_L is low.
  - cont_bloques = 0, err_seq = 0.
  - Reset mid-transfer discards all buffered entries; no partial output.
- Storage: 2 entries of 128 bits, 1-bit write/read pointers, 2-bit count (0, 1, 2 = EMPTY, ONE, FULL).
- Push: occurs when in_valid & in_ready at a clock edge. Write bloque_in at the write pointer, then toggle the write pointer.
- Pop: occurs when out_valid & out_ready at a clock edge. Toggle the read pointer and increment cont_bloques.
- in_ready = (count != 2), registered-state based; it does not depend on out_ready in the same cycle, so there is no bypass when FULL.
- out_valid = (count != 0).
- Outputs are driven from the head entry: entrada = head[127:32], nonce = head[31:0]. When EMPTY, entrada and nonce hold 0.
- Latency: a block pushed at edge N is visible at the outputs with out_valid=1 after edge N, i.e. one cycle. There is no combinational input-to-output path.
- State transitions:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE (new entry becomes head next cycle).
  - FULL: pop -> ONE; a push is impossible because in_ready=0.
- Ordering: strict FIFO.
- Output stability: the head entry is stable while out_valid=1 and out_ready=0.
- cont_bloques wraps from 0xFFFF to 0x0000 with no flag.
- in_valid while in_ready=0 is ignored; the source must hold the data.

Optional Feature:
- Macro: SEPARADOR_SEQ_CHECK_EN.
- Enabled:
  - A 32-bit register nonce_esperado is loaded on the first pop after reset with popped nonce+1.
  - On each later pop, if popped nonce != nonce_esperado, err_seq is set to 1 and stays 1 until reset.
  - nonce_esperado is always updated to popped nonce+1, mod 2^32, so 0xFFFFFFFF followed by 0x00000000 is legal.
- Disabled: the checker logic is absent and err_seq is tied to 0.

Test Plan:
- Reset then single push of bloque_in=0xAAAAAAAA_BBBBBBBB_CCCCCCCC_00000005 with out_ready=0 -> next cycle out_valid=1, entrada=0xAAAAAAAABBBBBBBBCCCCCCCC, nonce=0x00000005, in_ready=1.
- Push nonces 1 and 2 back-to-back with out_ready=0 -> in_ready=0 after the second push. Holding in_valid with nonce 3 is ignored. Raising out_ready pops 1 then 2; cont_bloques=2; nonce 3 is accepted after in_ready returns.
- Continuous streaming with in_valid=out_ready=1 and nonces 10..19 -> one output per cycle after the first, order preserved, count never reaches FULL, cont_bloques=10.
- Load 2 entries, assert reset_L=0 asynchronously mid-cycle -> out_valid, entrada, nonce and cont_bloques go to 0 immediately; after release, no stale data is output.
- Force 65536 pops -> cont_bloques wraps to 0x0000.
- With SEPARADOR_SEQ_CHECK_EN:
  - Nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 -> err_seq stays 0.
  - Then nonce 0x00000005 -> err_seq=1, and it holds through further in-sequence pops until reset.
